// File: rtl/exhaustive_stim_sweeper_if.sv
// Control and DUT-side signal bundle for the exhaustive truth-table sweeper.
interface exhaustive_stim_sweeper_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  logic              start;
  logic              abort;
  logic              mode_gray;
  logic [N_IN-1:0]   stim;
  logic [N_OUT-1:0]  dut_out;
  logic [N_OUT-1:0]  golden_out;
  logic              busy;
  logic              done;
  logic [N_IN:0]     err_count;
  logic              first_err_valid;
  logic [N_IN-1:0]   first_err_vec;

  // Board / test-harness side: drives controls and the DUT and golden responses.
  modport master (
    output start, abort, mode_gray, dut_out, golden_out,
    input  stim, busy, done, err_count, first_err_valid, first_err_vec
  );

  // Sweeper side.
  modport slave (
    input  start, abort, mode_gray, dut_out, golden_out,
    output stim, busy, done, err_count, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/exhaustive_stim_sweeper.sv
// Exhaustive truth-table tester: walks all 2^N_IN input vectors in binary or
// Gray order, holds each for DWELL clocks, and compares DUT vs golden outputs
// on the last clock of each dwell.
//
// state | meaning
// IDLE  | waiting for start; results of an aborted sweep stay visible
// APPLY | driving code(index), counting down the dwell
// DONE  | sweep complete; results held until next start
module exhaustive_stim_sweeper #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int DWELL = 10
) (
  input logic                    clk,
  input logic                    rst_n,
  exhaustive_stim_sweeper_if.slave bus
);

  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0]   CNT_RELOAD = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] LAST_IDX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] index_q, index_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gray_q, gray_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N_IN:0]   err_count_q, err_count_d;
  logic            fev_valid_q, fev_valid_d;
  logic [N_IN-1:0] fev_vec_q, fev_vec_d;

  logic [N_OUT-1:0] diff;
  logic             mismatch;
  logic             start_ok;
  logic             check_now;
  logic             last_vec;

  function automatic logic [N_IN-1:0] code_of(input logic [N_IN-1:0] i, input logic g);
    return g ? (i ^ (i >> 1)) : i;
  endfunction

  assign diff      = bus.dut_out ^ bus.golden_out;
  assign mismatch  = |diff;
  // abort outranks start everywhere, so a simultaneous pair never launches a sweep
  assign start_ok  = bus.start && !bus.abort;
  assign check_now = (cnt_q == '0);
  assign last_vec  = (index_q == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = APPLY;
      APPLY: begin
        if (bus.abort)                  state_d = IDLE;
        else if (check_now && last_vec) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; everything holds unless updated here.
  always_comb begin
    index_d     = index_q;
    cnt_d       = cnt_q;
    gray_d      = gray_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_count_d = err_count_q;
    fev_valid_d = fev_valid_q;
    fev_vec_d   = fev_vec_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok) begin
          index_d     = '0;
          cnt_d       = CNT_RELOAD;
          gray_d      = bus.mode_gray;
          stim_d      = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_count_d = '0;
          fev_valid_d = 1'b0;
          fev_vec_d   = '0;
        end
      end
      APPLY: begin
        if (bus.abort) begin
          busy_d = 1'b0;
          done_d = 1'b0;
        end else if (check_now) begin
          if (mismatch) begin
            err_count_d = err_count_q + 1'b1;
            if (!fev_valid_q) begin
              fev_valid_d = 1'b1;
              fev_vec_d   = stim_q;
            end
          end
          if (last_vec) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
            cnt_d   = CNT_RELOAD;
            stim_d  = code_of(index_q + 1'b1, gray_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q     <= '0;
      cnt_q       <= '0;
      gray_q      <= 1'b0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= '0;
      fev_valid_q <= 1'b0;
      fev_vec_q   <= '0;
    end else begin
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      gray_q      <= gray_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      fev_valid_q <= fev_valid_d;
      fev_vec_q   <= fev_vec_d;
    end
  end

  assign bus.stim            = stim_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err_count       = err_count_q;
  assign bus.first_err_valid = fev_valid_q;
  assign bus.first_err_vec   = fev_vec_q;

endmodule

// File: tb/tb_exhaustive_stim_sweeper.sv
// Directed bench for exhaustive_stim_sweeper (N_IN=3, N_OUT=2, DWELL=10).
module tb_exhaustive_stim_sweeper;
  localparam int N_IN  = 3;
  localparam int N_OUT = 2;
  localparam int DWELL = 10;
  localparam int NV    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] fault_mask = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N_IN-1:0] exp_q[$];
  logic [N_IN-1:0] bin_order  [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [N_IN-1:0] gray_order [NV] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  exhaustive_stim_sweeper_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  exhaustive_stim_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .DWELL(DWELL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lab "DUT" and its golden model; fault_mask flips dut_out[0] on chosen vectors.
  assign bus.golden_out = {bus.stim[2] ^ bus.stim[0], bus.stim[1] & ~bus.stim[0]};
  assign bus.dut_out    = bus.golden_out ^ {1'b0, fault_mask[bus.stim]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag, input int e_err, input bit e_fv, input int e_fvec);
    chk({tag, "_err_count"}, 32'(bus.err_count), 32'(e_err));
    chk({tag, "_first_valid"}, 32'(bus.first_err_valid), 32'(e_fv));
    chk({tag, "_first_vec"}, 32'(bus.first_err_vec), 32'(e_fvec));
  endtask

  // Runs one sweep from IDLE/DONE. restart_at/abort_at/reset_at are cycle
  // offsets into the sweep (-1 = never). Expected stim order comes from the
  // scoreboard queue; expected error results are accumulated as each vector's
  // dwell ends.
  task automatic do_sweep(input bit gray, input int restart_at, input int abort_at,
                          input int reset_at);
    logic [N_IN-1:0] cur;
    int m_err;
    bit m_fv;
    int m_fvec;
    exp_q.delete();
    for (int i = 0; i < NV; i++) exp_q.push_back(gray ? gray_order[i] : bin_order[i]);
    m_err = 0; m_fv = 1'b0; m_fvec = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode_gray = gray;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode_gray = ~gray;
    cur = exp_q.pop_front();
    for (int k = 0; k < NV * DWELL; k++) begin
      if (k > 0 && (k % DWELL) == 0) begin
        if (fault_mask[cur]) begin
          m_err++;
          if (!m_fv) begin m_fv = 1'b1; m_fvec = int'(cur); end
        end
        cur = exp_q.pop_front();
      end
      chk("stim", 32'(bus.stim), 32'(cur));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("done_low", 32'(bus.done), 32'd0);
      chk_results("sweep", m_err, m_fv, m_fvec);
      bus.start = (k == restart_at);
      if (k == abort_at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_stim", 32'(bus.stim), 32'(cur));
        chk_results("abort", m_err, m_fv, m_fvec);
        repeat (3) @(negedge clk);
        chk("idle_stim_hold", 32'(bus.stim), 32'(cur));
        chk("idle_busy", 32'(bus.busy), 32'd0);
        return;
      end
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_stim", 32'(bus.stim), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk_results("rst", 0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (fault_mask[cur]) begin
      m_err++;
      if (!m_fv) begin m_fv = 1'b1; m_fvec = int'(cur); end
    end
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_done", 32'(bus.done), 32'd1);
    chk("end_stim", 32'(bus.stim), 32'(cur));
    chk_results("end", m_err, m_fv, m_fvec);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode_gray = 1'b0;
    #1;
    chk("por_stim", 32'(bus.stim), 32'd0);
    chk("por_busy", 32'(bus.busy), 32'd0);
    chk("por_done", 32'(bus.done), 32'd0);
    chk_results("por", 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean binary and Gray sweeps.
    do_sweep(1'b0, -1, -1, -1);
    do_sweep(1'b1, -1, -1, -1);

    // Two injected faults in binary order.
    fault_mask = 8'b0110_0000;
    do_sweep(1'b0, -1, -1, -1);

    // In DONE, start+abort together must not launch a sweep.
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_start_abort_busy", 32'(bus.busy), 32'd0);
    chk("done_start_abort_done", 32'(bus.done), 32'd1);
    chk_results("done_hold", 2, 1'b1, 5);

    // Restart ignored at vector 3, abort at vector 4 with fault on 5 armed.
    fault_mask = 8'b0010_0000;
    do_sweep(1'b0, 35, 45, -1);

    // Reset at vector 6 after the stim==5 mismatch was recorded.
    do_sweep(1'b0, -1, -1, 65);
    repeat (2) @(negedge clk);
    chk("post_rst_idle_stim", 32'(bus.stim), 32'd0);
    do_sweep(1'b0, -1, -1, -1);

    // From DONE, new fault set in Gray order; counters clear at start.
    fault_mask = 8'b1000_0100;
    do_sweep(1'b1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/exhaustive_stim_sweeper.md
Name: exhaustive_stim_sweeper

Overview:
- Synthesisable, parametrised exhaustive truth-table tester for small combinational lab blocks.
- Drives every input combination of an N_IN-bit DUT in binary or Gray order and holds each vector for DWELL clocks.
- Samples the DUT outputs and compares them against a golden-model output; reports mismatch count and first failing vector.
- Sits between board switches/LEDs (start, busy/done/err) and the DUT plus its golden model, so tests run on hardware without a simulator.

Parameters:
- N_IN, 3, DUT input width; 2^N_IN vectors are swept (1..16).
- N_OUT, 2, DUT output width compared per vector (1..32).
- DWELL, 10, clocks each vector is held (>=2).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level-sampled; begins a sweep when in IDLE or DONE.
- abort  input  1  ends a sweep early; returns to IDLE.
- mode_gray  input  1  0 = binary order, 1 = Gray order; latched at start.
- stim  output  N_IN  vector applied to the DUT and to the golden model.
- dut_out  input  N_OUT  DUT outputs.
- golden_out  input  N_OUT  expected outputs.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep completion until the next start or reset.
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep.
- first_err_valid  output  1  at least one mismatch has been recorded.
- first_err_vec  output  N_IN  stim value of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stim=0, busy=0, done=0, err_count=0, first_err_valid=0, first_err_vec=0; index=0, dwell counter=0, latched mode=0. These are held immediately and while rst_n is low. Reset mid-sweep aborts with no residual state.
- States:
  - IDLE -> APPLY on start=1.
  - APPLY -> DONE after the last vector check.
  - APPLY -> IDLE on abort.
  - DONE -> APPLY on start=1.
- Start edge (IDLE/DONE with start=1):
  - index=0, cnt=DWELL-1, mode latched.
  - err_count, first_err_valid and first_err_vec cleared; done=0, busy=1.
  - stim=code(0) is visible in the cycle after start is sampled.
- code(i) = i in binary mode; i ^ (i>>1) in Gray mode.
- APPLY:
  - stim=code(index) is held for exactly DWELL cycles.
  - cnt decrements each clock.
  - When cnt==0, on that edge: compare dut_out vs golden_out (all N_OUT bits).
  - On mismatch: err_count+1; if first_err_valid=0, then first_err_valid=1 and first_err_vec=code(index).
  - Same edge: if index==2^N_IN-1, go to DONE (busy=0, done=1, stim holds the last vector); else index+1 and cnt reload DWELL-1.
- Total busy duration = 2^N_IN*DWELL cycles. No vector is checked before DWELL-1 cycles of settling.
- err_count max is 2^N_IN, which fits N_IN+1 bits; no saturation needed.
- start while in APPLY is ignored; sweep order and counters are unaffected.
- abort in APPLY (priority over the check on the same edge):
  - Go to IDLE; busy=0, done=0.
  - err_count and first_err_* keep values from the vectors already checked; stim holds.
- abort in IDLE/DONE has no effect. start and abort together in IDLE/DONE: abort wins, no sweep starts.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- N_IN=3, DWELL=10, binary, golden_out tied to DUT outputs, start pulsed -> stim steps 0,1,..,7, each held 10 clocks; busy high for 80 cycles; done=1, err_count=0, first_err_valid=0.
- Same setup, mode_gray=1 -> stim sequence 0,1,3,2,6,7,5,4; done after 80 cycles, err_count=0.
- Inject faults: invert dut_out[0] when stim==5 and when stim==6 (binary) -> err_count=2, first_err_valid=1, first_err_vec=5.
- Re-pulse start mid-sweep at vector 3, then assert abort at vector 4 with the stim==5 fault armed -> sweep not restarted; IDLE, busy=0, done=0, err_count=0, stim=4.
- Assert rst_n=0 mid-sweep at vector 6 after a recorded mismatch -> all outputs 0 immediately, state IDLE. A fresh start after release sweeps from stim=0.
- Let a sweep reach DONE, change the fault, pulse start -> counters clear at start; new sweep reports only the new mismatches; done stays low until the new completion.
